// File: rtl/counter_seq_b4.sv
// Command sequencer for the 4-bit mode counter: queues mode/load/length
// commands, issues them back-to-back, and tallies counter ripple-carry.
//
// Ports:
//   sq_clk, sq_reset        clock, synchronous active-low reset
//   sq_cmd_valid/_ready     command handshake into the FIFO
//   sq_cmd_mode/_data/_len  command payload (len = cycles - 1)
//   sq_abort                flush queue and stop issuing
//   sq_rco                  ripple-carry from the counter
//   sq_enable/_mode/_D      registered counter controls
//   sq_busy, sq_done        activity flag, per-command completion pulse
//   sq_rco_cnt              saturating tally of enabled rco cycles
module counter_seq_b4 #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             sq_clk,
  input  logic             sq_reset,
  input  logic             sq_cmd_valid,
  output logic             sq_cmd_ready,
  input  logic [1:0]       sq_cmd_mode,
  input  logic [3:0]       sq_cmd_data,
  input  logic [LEN_W-1:0] sq_cmd_len,
  input  logic             sq_abort,
  input  logic             sq_rco,
  output logic             sq_enable,
  output logic [1:0]       sq_mode,
  output logic [3:0]       sq_D,
  output logic             sq_busy,
  output logic             sq_done,
  output logic [7:0]       sq_rco_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [3:0]       data;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic             en_q, done_q, busy_q;
  logic [1:0]       mode_q;
  logic [3:0]       d_q;
  logic [7:0]       rco_q;

  logic push, pop, last, run_d, busy_d;
  cmd_t head;

  // Ready depends only on reset, abort and occupancy, never on valid.
  assign sq_cmd_ready = sq_reset & ~sq_abort & (cnt_q < CW'(DEPTH));
  assign push = sq_cmd_valid & sq_cmd_ready;
  assign last = (state_q == RUN) && (rem_q == '0);
  // Pop when idle, or on the final cycle of the running command so the
  // next one follows without an enable gap.
  assign pop  = (cnt_q != '0) && ((state_q == IDLE) || last);
  assign head = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign run_d  = pop | ((state_q == RUN) & ~last);
  assign busy_d = run_d | (cnt_d != '0);

  always_ff @(posedge sq_clk) begin
    if (push) begin
      mem_q[wr_q] <= '{mode: sq_cmd_mode,
                       data: sq_cmd_data,
                       len:  sq_cmd_len};
    end
  end

  always_ff @(posedge sq_clk) begin
    if (!sq_reset || sq_abort) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      rem_q   <= '0;
      en_q    <= 1'b0;
      mode_q  <= 2'b00;
      d_q     <= 4'h0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= last;
      if (pop) begin
        state_q <= RUN;
        en_q    <= 1'b1;
        mode_q  <= head.mode;
        d_q     <= head.data;
        rem_q   <= head.len;
      end else if (last) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
        mode_q  <= 2'b00;
        d_q     <= 4'h0;
      end else if (state_q == RUN) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  // The tally survives abort; only reset clears it.
  always_ff @(posedge sq_clk) begin
    if (!sq_reset) begin
      rco_q <= 8'd0;
    end else if (sq_rco && en_q && rco_q != 8'hFF) begin
      rco_q <= rco_q + 8'd1;
    end
  end

  assign sq_enable  = en_q;
  assign sq_mode    = mode_q;
  assign sq_D       = d_q;
  assign sq_done    = done_q;
  assign sq_busy    = busy_q;
  assign sq_rco_cnt = rco_q;

endmodule

// File: tb/tb_counter_seq_b4.sv
// Testbench for counter_seq_b4: directed table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_counter_seq_b4;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vld, ab, rco;
  logic [1:0] md;
  logic [3:0] dt;
  logic [3:0] ln;
  logic       rdy, en, done, busy;
  logic [1:0] omd;
  logic [3:0] od;
  logic [7:0] cnt;

  counter_seq_b4 #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .sq_clk      (clk),
    .sq_reset    (rst),
    .sq_cmd_valid(vld),
    .sq_cmd_ready(rdy),
    .sq_cmd_mode (md),
    .sq_cmd_data (dt),
    .sq_cmd_len  (ln),
    .sq_abort    (ab),
    .sq_rco      (rco),
    .sq_enable   (en),
    .sq_mode     (omd),
    .sq_D        (od),
    .sq_busy     (busy),
    .sq_done     (done),
    .sq_rco_cnt  (cnt)
  );

  typedef struct {
    int mode;
    int data;
    int len;
  } cmd_t;

  // Reference model: a command queue plus "cycles left" of the current one.
  cmd_t m_q[$];
  cmd_t m_cur;
  bit   m_run;
  int   m_left;
  int   m_en, m_md, m_d, m_done, m_busy, m_rco;

  int n_cmp = 0;
  int n_bad = 0;
  bit acc_last;
  int done_seen;
  int en_seen;

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc;
    cmd_t c;
    if (!rst) begin
      m_q.delete();
      m_run = 0; m_left = 0;
      m_en = 0; m_md = 0; m_d = 0;
      m_done = 0; m_busy = 0; m_rco = 0;
    end else begin
      if (rco && m_en != 0 && m_rco < 255) m_rco++;
      if (ab) begin
        m_q.delete();
        m_run = 0; m_left = 0;
        m_en = 0; m_md = 0; m_d = 0;
        m_done = 0; m_busy = 0;
      end else begin
        acc = vld && (m_q.size() < DEPTH);
        m_done = (m_run && m_left == 1) ? 1 : 0;
        if (m_run && m_left > 1) begin
          m_left--;
        end else if (m_q.size() > 0) begin
          m_cur  = m_q.pop_front();
          m_left = m_cur.len + 1;
          m_run  = 1;
        end else begin
          m_run = 0;
        end
        if (acc) begin
          c.mode = int'(md); c.data = int'(dt); c.len = int'(ln);
          m_q.push_back(c);
        end
        m_en   = m_run ? 1 : 0;
        m_md   = m_run ? m_cur.mode : 0;
        m_d    = m_run ? m_cur.data : 0;
        m_busy = (m_run || m_q.size() > 0) ? 1 : 0;
      end
    end
  endtask

  task automatic step();
    #1;
    chk("ready", rdy,
        (rst && !ab && m_q.size() < DEPTH) ? 1 : 0);
    acc_last = vld && rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk("enable", en, m_en);
    chk("mode", omd, m_md);
    chk("D", od, m_d);
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("rco_cnt", cnt, m_rco);
    if (done) done_seen++;
    if (en) en_seen++;
  endtask

  typedef struct {
    int rst, vld, md, dt, ln;
    int e_en, e_md, e_d, e_done, e_busy, e_rdy;
  } vec_t;

  function automatic vec_t mkv(int r, int v, int m, int d, int l,
                               int een, int emd, int ed,
                               int edn, int eb, int er);
    vec_t x;
    x.rst = r; x.vld = v; x.md = m; x.dt = d; x.ln = l;
    x.e_en = een; x.e_md = emd; x.e_d = ed;
    x.e_done = edn; x.e_busy = eb; x.e_rdy = er;
    return x;
  endfunction

  vec_t tbl[17];
  int nacc;
  int guard;

  initial begin
    rst = 0; vld = 0; ab = 0; rco = 0;
    md = 0; dt = 0; ln = 0;

    // reset held with valid, then single command, then seamless pair
    tbl[0]  = mkv(0,1,2,5,3, 0,0,0,0,0,0);
    tbl[1]  = mkv(0,1,2,5,3, 0,0,0,0,0,0);
    tbl[2]  = mkv(0,1,2,5,3, 0,0,0,0,0,0);
    tbl[3]  = mkv(1,0,0,0,0, 0,0,0,0,0,1);
    tbl[4]  = mkv(1,1,2,5,3, 0,0,0,0,1,1);
    tbl[5]  = mkv(1,0,0,0,0, 1,2,5,0,1,1);
    tbl[6]  = mkv(1,0,0,0,0, 1,2,5,0,1,1);
    tbl[7]  = mkv(1,0,0,0,0, 1,2,5,0,1,1);
    tbl[8]  = mkv(1,0,0,0,0, 1,2,5,0,1,1);
    tbl[9]  = mkv(1,0,0,0,0, 0,0,0,1,0,1);
    tbl[10] = mkv(1,0,0,0,0, 0,0,0,0,0,1);
    tbl[11] = mkv(1,1,0,2,1, 0,0,0,0,1,1);
    tbl[12] = mkv(1,1,3,9,0, 1,0,2,0,1,1);
    tbl[13] = mkv(1,0,0,0,0, 1,0,2,0,1,1);
    tbl[14] = mkv(1,0,0,0,0, 1,3,9,1,1,1);
    tbl[15] = mkv(1,0,0,0,0, 0,0,0,1,0,1);
    tbl[16] = mkv(1,0,0,0,0, 0,0,0,0,0,1);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst[0]; vld = tbl[i].vld[0];
      md = tbl[i].md[1:0]; dt = tbl[i].dt[3:0];
      ln = tbl[i].ln[3:0];
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tv%0d_en", i), en, tbl[i].e_en);
      chk($sformatf("tv%0d_mode", i), omd, tbl[i].e_md);
      chk($sformatf("tv%0d_D", i), od, tbl[i].e_d);
      chk($sformatf("tv%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tv%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tv%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk($sformatf("tv%0d_rco", i), cnt, 0);
    end

    // full FIFO: six long commands offered continuously
    vld = 0;
    done_seen = 0;
    nacc = 0;
    vld = 1; ln = 15; md = 0; dt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (acc_last) begin
        nacc++;
        md = 2'(nacc); dt = 4'(nacc);
        if (nacc == 6) vld = 0;
      end
    end
    chk("full_acc", nacc, 5);
    #1 chk("full_rdy", rdy, 0);
    guard = 0;
    while (nacc < 6 && guard < 40) begin
      step();
      guard++;
      if (acc_last) begin
        nacc++;
        if (nacc == 6) vld = 0;
      end
    end
    chk("full_6th", nacc, 6);
    vld = 0;
    guard = 0;
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    chk("full_drain", busy, 0);
    chk("full_dones", done_seen, 6);

    // abort during 3rd cycle of a len=7 command with two queued
    vld = 1; md = 1; dt = 3; ln = 7; step();
    md = 2; dt = 4; ln = 2; step();
    md = 0; dt = 6; ln = 4; step();
    vld = 0; step();
    ab = 1; step();
    ab = 0;
    chk("abort_en", en, 0);
    chk("abort_mode", omd, 0);
    chk("abort_busy", busy, 0);
    #1 chk("abort_rdy", rdy, 1);
    done_seen = 0;
    for (int c = 0; c < 4; c++) step();
    chk("abort_nodone", done_seen, 0);
    done_seen = 0; en_seen = 0;
    vld = 1; md = 2; dt = 1; ln = 3; step();
    vld = 0;
    for (int c = 0; c < 8; c++) step();
    chk("post_abort_en", en_seen, 4);
    chk("post_abort_done", done_seen, 1);

    // rco saturation, idle hold, reset clear
    rco = 1; vld = 1; ln = 15;
    for (int c = 0; c < 300; c++) begin
      md = 2'($urandom_range(0, 3));
      step();
    end
    chk("rco_sat", cnt, 255);
    vld = 0; ab = 1; step();
    ab = 0;
    for (int c = 0; c < 10; c++) step();
    chk("rco_idle_en", en, 0);
    chk("rco_hold", cnt, 255);
    rst = 0; step();
    chk("rco_reset", cnt, 0);
    rst = 1; rco = 0; step();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      vld = ($urandom_range(0, 9) < 7);
      md  = 2'($urandom_range(0, 3));
      dt  = 4'($urandom_range(0, 15));
      ln  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(0, 2));
      ab  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) != 0);
      rco = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_seq_b4.md
# counter_seq_b4

Command sequencer that sits directly upstream of the 4-bit mode counter and drives its enable, mode and parallel-load data. Commands (mode, load value, run length) arrive over a valid/ready handshake into a small FIFO. They are issued back-to-back to the counter, so its enable never drops between queued commands. Ripple-carry events returned by the counter are tallied in a saturating event counter.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- LEN_W, 4: width of the run-length field.

Ports:
- sq_clk  in  1  clock; all logic on rising edge.
- sq_reset  in  1  reset; synchronous, active-low.
- sq_cmd_valid  in  1  command present.
- sq_cmd_ready  out  1  FIFO can accept; transfer when valid&ready at an edge.
- sq_cmd_mode  in  2  counter mode: 00 +3, 01 −1, 10 +1, 11 load.
- sq_cmd_data  in  4  load value; meaningful for mode 11, carried for all modes.
- sq_cmd_len  in  LEN_W  run length minus one; command runs len+1 cycles.
- sq_abort  in  1  flush FIFO and stop issuing.
- sq_rco  in  1  ripple-carry from counter.
- sq_enable  out  1  counter enable.
- sq_mode  out  2  counter mode.
- sq_D  out  4  counter parallel data.
- sq_busy  out  1  RUN state or FIFO non-empty.
- sq_done  out  1  one-cycle pulse per completed command.
- sq_rco_cnt  out  8  saturating count of enabled rco cycles.

## Operation
- FIFO:
  - Push on valid&ready; pop driven by FSM.
  - Push and pop at the same edge leave the occupancy unchanged.
  - Occupancy register spans 0..DEPTH.
- sq_cmd_ready = sq_reset & !sq_abort & (occupancy < DEPTH).
  - No combinational path from valid to ready.
  - A push is never accepted while full, even if a pop occurs at the same edge.
- FSM states IDLE and RUN.
  - IDLE:
    - sq_enable=0, sq_mode=00, sq_D=0.
    - If FIFO non-empty: pop, load mode/D/remaining=len into output registers, go RUN.
  - RUN:
    - sq_enable=1; mode/D held from the current command.
    - remaining≠0: remaining−1.
    - remaining=0: pulse sq_done next cycle. If FIFO non-empty, pop the next command, stay RUN (seamless). Otherwise go IDLE.
- sq_rco_cnt:
  - +1 at each edge where sq_rco=1 and sq_enable=1.
  - Saturates at 255; rco while sq_enable=0 is ignored.
  - Cleared only by reset.
- sq_abort=1 at an edge (reset inactive):
  - FIFO emptied, FSM to IDLE.
  - sq_enable/sq_mode/sq_D/sq_done cleared.
  - Same-cycle push discarded.
  - sq_rco_cnt retained.
- Reset has priority over abort. Abort has priority over push/pop/FSM.

## Timing
- All outputs except sq_cmd_ready are registered.
- Reset (sq_reset=0 at an edge) sets:
  - sq_enable=0, sq_mode=00, sq_D=0, sq_busy=0, sq_done=0, sq_rco_cnt=0.
  - FIFO empty, FSM IDLE.
  - sq_cmd_ready=0 while sq_reset is low.
- Reset mid-command: the command is lost, and the next cycle shows reset values.
- Acceptance at edge k into an empty FIFO in IDLE:
  - Pop at edge k+1.
  - sq_enable high for cycles starting at edges k+1 … k+1+len.
  - sq_done high for the cycle starting at edge k+2+len.
  - sq_enable low from that same edge if no further command is queued.
- Back-to-back: the next command's mode/D appear at the edge immediately after the previous command's last cycle; sq_enable stays 1.
- Full FIFO: a pop at edge p makes sq_cmd_ready high from p; the earliest new acceptance is at edge p+1.
- sq_busy:
  - Registered.
  - High the cycle after a push into an idle block.
  - Low the cycle after the last command's final RUN cycle.
- len=0: exactly one enabled cycle, with sq_done the following cycle.

## Test plan
- **Reset:** hold sq_reset=0 for 3 cycles with sq_cmd_valid=1 → sq_cmd_ready=0, no acceptance, all outputs 0; after release, ready=1 the next cycle.
- **Single command:** mode=10, len=3, accepted at edge k → sq_enable=1, sq_mode=10 for exactly 4 cycles (edges k+1..k+4); sq_done single pulse at k+5; sq_enable=0 and sq_busy=0 from k+5.
- **Seamless:** (mode 00, len 1) then (mode 11, D=9, len 0) accepted on consecutive edges → sq_enable high 3 consecutive cycles with modes 00, 00, 11 and sq_D=9 on the third; two sq_done pulses.
- **Full:** 6 commands with len=15 offered continuously from idle → 5 accepted (1 running + 4 queued), ready low; 6th accepted one edge after the first command's final cycle; all 6 issued in order.
- **Abort:** sq_abort for one cycle during the 3rd cycle of a len=7 command with 2 queued → next cycle sq_enable=0, sq_mode=00, FIFO empty, ready=1, no sq_done; a subsequent command behaves as in the single-command scenario.
- **RCO tally:** sq_rco=1 for 300 enabled cycles, then 10 cycles with sq_enable=0 → sq_rco_cnt stops at 255, unchanged during idle; reset returns it to 0.
